// File: rtl/mux_arbiter_2to1.sv
// Round-robin arbiter for the 2:1 PHY lane mux. Two per-lane FIFOs feed a
// bounded-burst grant FSM and a registered valid/ready output stage.
module mux_arbiter_2to1 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] in0,
    input  logic              valid_bit0,
    output logic              full0,
    input  logic [DATA_W-1:0] in1,
    input  logic              valid_bit1,
    output logic              full1,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_bit_out,
    output logic              selector,
    output logic [1:0]        err_overflow
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BCNT_W-1:0]    burst_q, burst_d, burst_base;
    logic                 last_q, last_d;
    logic                 sel_q;

    logic [1:0]               push_req;
    logic [1:0][DATA_W-1:0]   din;
    logic [1:0]               nonempty;
    logic [1:0]               full_vec;
    logic [1:0][DATA_W-1:0]   rd_word;

    logic                 grant_vld;
    logic                 grant_lane;
    logic                 burst_clr;
    logic                 cur_lane;
    logic                 oth_lane;
    logic                 out_en;
    logic                 pop_en;

    logic [DATA_W-1:0]    data_p1;
    logic                 vld_p1;

    assign push_req = {valid_bit1, valid_bit0};
    assign din      = {in1, in0};

    // ---- Stage p0: per-lane input FIFOs ----
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lane
            localparam logic LANE = 1'(g);

            logic [DATA_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr;
            logic [PTR_W-1:0]  rd_ptr;
            logic [CNT_W-1:0]  count;
            logic [CNT_W-1:0]  count_d;
            logic              full_q;
            logic              err_q;
            logic              push_ok;
            logic              pop_ok;

            // full is registered, so a push on the edge that frees a slot is
            // still refused and flagged.
            assign push_ok = push_req[g] & ~full_q;
            assign pop_ok  = pop_en & (grant_lane == LANE);

            always_comb begin
                count_d = count;
                case ({push_ok, pop_ok})
                    2'b10:   count_d = count + 1'b1;
                    2'b01:   count_d = count - 1'b1;
                    default: count_d = count;
                endcase
            end

            always_ff @(posedge clk) begin
                if (push_ok) begin
                    mem[wr_ptr] <= din[g];
                end
            end

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    full_q <= 1'b0;
                    err_q  <= 1'b0;
                end else begin
                    if (push_ok) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop_ok) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    count  <= count_d;
                    full_q <= (count_d == FULL_CNT);
                    err_q  <= err_q | (push_req[g] & full_q);
                end
            end

            assign nonempty[g]     = (count != '0);
            assign full_vec[g]     = full_q;
            assign rd_word[g]      = mem[rd_ptr];
            assign err_overflow[g] = err_q;
        end
    endgenerate

    // ---- Grant decision: combinational from state, counts and burst ----
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_vld  = 1'b0;
        grant_lane = sel_q;
        burst_clr  = 1'b0;
        cur_lane   = (state_q == GRANT1);
        oth_lane   = ~cur_lane;

        unique case (state_q)
            IDLE: begin
                burst_clr = 1'b1;
                if (nonempty == 2'b11) begin
                    grant_vld  = 1'b1;
                    grant_lane = ~last_q;
                end else if (nonempty[0]) begin
                    grant_vld  = 1'b1;
                    grant_lane = 1'b0;
                end else if (nonempty[1]) begin
                    grant_vld  = 1'b1;
                    grant_lane = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (nonempty[cur_lane] && (burst_q < BURST_MAX)) begin
                    grant_vld  = 1'b1;
                    grant_lane = cur_lane;
                end else if (nonempty[oth_lane]) begin
                    grant_vld  = 1'b1;
                    grant_lane = oth_lane;
                    burst_clr  = 1'b1;
                end else if (nonempty[cur_lane]) begin
                    // burst exhausted but the other lane has nothing: restart it
                    grant_vld  = 1'b1;
                    grant_lane = cur_lane;
                    burst_clr  = 1'b1;
                end else begin
                    state_d = IDLE;
                    last_d  = cur_lane;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_vld) begin
            state_d = grant_lane ? GRANT1 : GRANT0;
        end
    end

    assign out_en     = ~vld_p1 | out_ready;
    assign pop_en     = out_en & grant_vld;
    assign burst_base = burst_clr ? '0 : burst_q;
    assign burst_d    = burst_base + BCNT_W'(pop_en);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            burst_q <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            if (grant_vld) begin
                sel_q <= grant_lane;
            end
        end
    end

    // ---- Stage p1: registered output with valid/ready hold ----
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (out_en) begin
            if (pop_en) begin
                data_p1 <= rd_word[grant_lane];
                vld_p1  <= 1'b1;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign data_out      = data_p1;
    assign valid_bit_out = vld_p1;
    assign selector      = sel_q;
    assign full0         = full_vec[0];
    assign full1         = full_vec[1];

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Directed bench for mux_arbiter_2to1: expected words go into a queue when
// stimulus is driven and are checked as the output handshake completes.
module tb_mux_arbiter_2to1;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BURST_LEN  = 2;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic [DATA_W-1:0] in0 = '0;
    logic              valid_bit0 = 1'b0;
    logic              full0;
    logic [DATA_W-1:0] in1 = '0;
    logic              valid_bit1 = 1'b0;
    logic              full1;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              valid_bit_out;
    logic              selector;
    logic [1:0]        err_overflow;

    int n_assert = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    mux_arbiter_2to1 #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .in0          (in0),
        .valid_bit0   (valid_bit0),
        .full0        (full0),
        .in1          (in1),
        .valid_bit1   (valid_bit1),
        .full1        (full1),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .valid_bit_out(valid_bit_out),
        .selector     (selector),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the output handshake is scored mid-cycle before the edge.
    task automatic tick();
        @(negedge clk);
        if (valid_bit_out && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(exp_q.size() > 0), 32'd1);
            end else begin
                check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            tick();
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(valid_bit_out), 32'd0);
        check("rst_selector", 32'(selector), 32'd0);
        check("rst_full", 32'({full1, full0}), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        reset_L = 1'b1;

        // Test 1: reset mid-stream, no clock edge
        out_ready  = 1'b0;
        valid_bit0 = 1'b1; in0 = 8'h55; tick();
        in0 = 8'h66; tick();
        valid_bit0 = 1'b0; tick();
        check("t1_pre_valid", 32'(valid_bit_out), 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        check("t1_async_data", 32'(data_out), 32'd0);
        check("t1_async_valid", 32'(valid_bit_out), 32'd0);
        check("t1_async_sel", 32'(selector), 32'd0);
        check("t1_async_full", 32'({full1, full0}), 32'd0);
        check("t1_async_err", 32'(err_overflow), 32'd0);
        @(posedge clk);
        #1;
        reset_L   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_idle_valid", 32'(valid_bit_out), 32'd0);
        end

        // Test 3: fairness with BURST_LEN = 2
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        for (int k = 0; k < 4; k++) begin
            valid_bit0 = 1'b1; in0 = 8'h10 + 8'(k);
            valid_bit1 = 1'b1; in1 = 8'h20 + 8'(k);
            tick();
            if (valid_bit_out) check("t3_selector", 32'(selector), 32'(data_out[5]));
        end
        valid_bit0 = 1'b0;
        valid_bit1 = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
            if (valid_bit_out) check("t3_selector", 32'(selector), 32'(data_out[5]));
        end
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Test 2: single lane latency and order
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        valid_bit0 = 1'b1; in0 = 8'hA1; tick();
        check("t2_not_yet", 32'(valid_bit_out), 32'd0);
        in0 = 8'hA2; tick();
        check("t2_first_data", 32'(data_out), 32'hA1);
        check("t2_first_valid", 32'(valid_bit_out), 32'd1);
        check("t2_sel", 32'(selector), 32'd0);
        in0 = 8'hA3; tick();
        check("t2_second_data", 32'(data_out), 32'hA2);
        check("t2_sel", 32'(selector), 32'd0);
        valid_bit0 = 1'b0; tick();
        check("t2_third_data", 32'(data_out), 32'hA3);
        check("t2_sel", 32'(selector), 32'd0);
        drain("t2_drained", 10);
        tick();
        check("t2_idle_valid", 32'(valid_bit_out), 32'd0);

        // Test 4: backpressure hold
        out_ready = 1'b0;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        valid_bit0 = 1'b1; in0 = 8'h41; tick();
        in0 = 8'h42; tick();
        in0 = 8'h43; tick();
        valid_bit0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_data", 32'(data_out), 32'h41);
            check("t4_hold_valid", 32'(valid_bit_out), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("t4_next_data", 32'(data_out), 32'h42);
        drain("t4_drained", 10);

        // Test 5: overflow on lane 1
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'h51 + 8'(k));
            valid_bit1 = 1'b1; in1 = 8'h51 + 8'(k);
            if (k == 4) check("t5_not_full", 32'(full1), 32'd0);
            tick();
        end
        check("t5_full", 32'(full1), 32'd1);
        check("t5_no_err_yet", 32'(err_overflow), 32'd0);
        in1 = 8'hE0; tick();
        in1 = 8'hE1; tick();
        valid_bit1 = 1'b0;
        check("t5_err", 32'(err_overflow), 32'b10);
        check("t5_still_full", 32'(full1), 32'd1);
        out_ready = 1'b1;
        drain("t5_drained", 20);
        tick();
        check("t5_no_extra", 32'(valid_bit_out), 32'd0);
        tick();
        check("t5_full_clear", 32'(full1), 32'd0);

        // Test 6: tie after idle, lane 1 served last
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h71);
        valid_bit0 = 1'b1; in0 = 8'h61;
        valid_bit1 = 1'b1; in1 = 8'h71;
        tick();
        valid_bit0 = 1'b0;
        valid_bit1 = 1'b0;
        tick();
        check("t6_sel", 32'(selector), 32'd0);
        check("t6_data", 32'(data_out), 32'h61);
        check("t6_valid", 32'(valid_bit_out), 32'd1);
        drain("t6_drained", 10);
        check("t6_err_sticky", 32'(err_overflow), 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
